// File: rtl/demux_1_2_stream.sv
// demux_1_2_stream: 1-to-2 valid/ready stream demux with a registered holding slot per output.
// Optional DEMUX_BEAT_CNT_EN adds per-output delivered-beat counters CNT1/CNT2.
module demux_1_2_stream #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [W-1:0]     I,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic             S,
    output logic [W-1:0]     Y1,
    output logic             Y1_VALID,
    input  logic             Y1_READY,
    output logic [W-1:0]     Y2,
    output logic             Y2_VALID,
    input  logic             Y2_READY
`ifdef DEMUX_BEAT_CNT_EN
    ,
    output logic [CNT_W-1:0] CNT1,
    output logic [CNT_W-1:0] CNT2
`endif
);
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [W-1:0] y1_q, y1_d, y2_q, y2_d;
    logic         v1_q, v1_d, v2_q, v2_d;
    logic         acc1, acc2, drn1, drn2;

    always_comb begin
        I_READY = S ? (!v2_q | Y2_READY) : (!v1_q | Y1_READY);
        acc1    = I_VALID & I_READY & !S;
        acc2    = I_VALID & I_READY & S;
        drn1    = v1_q & Y1_READY;
        drn2    = v2_q & Y2_READY;
        y1_d    = acc1 ? I : y1_q;
        y2_d    = acc2 ? I : y2_q;
        v1_d    = acc1 | (v1_q & !Y1_READY);
        v2_d    = acc2 | (v2_q & !Y2_READY);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y1_q <= '0;
            y2_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            y1_q <= y1_d;
            y2_q <= y2_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    assign Y1       = y1_q;
    assign Y2       = y2_q;
    assign Y1_VALID = v1_q;
    assign Y2_VALID = v2_q;

`ifdef DEMUX_BEAT_CNT_EN
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    // Counters wrap naturally at 2^CNT_W.
    always_comb begin
        cnt1_d = cnt1_q + CNT_W'(drn1);
        cnt2_d = cnt2_q + CNT_W'(drn2);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign CNT1 = cnt1_q;
    assign CNT2 = cnt2_q;
`else
    logic unused_drn;
    assign unused_drn = drn1 ^ drn2;
`endif
endmodule

// File: tb/tb_demux_1_2_stream.sv
// tb_demux_1_2_stream: directed self-checking bench for demux_1_2_stream (CNT_W=4).
module tb_demux_1_2_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_d;
    logic       i_valid, i_ready, s;
    logic [7:0] y1, y2;
    logic       y1_valid, y1_ready, y2_valid, y2_ready;
    int         n_pass = 0;
    int         n_tot = 0;
`ifdef DEMUX_BEAT_CNT_EN
    logic [3:0] cnt1, cnt2;
`endif

    always #5 clk = ~clk;

    demux_1_2_stream #(.W(8), .CNT_W(4)) dut (
        .CLK(clk), .RST_N(rst_n), .I(i_d), .I_VALID(i_valid), .I_READY(i_ready), .S(s),
        .Y1(y1), .Y1_VALID(y1_valid), .Y1_READY(y1_ready),
        .Y2(y2), .Y2_VALID(y2_valid), .Y2_READY(y2_ready)
`ifdef DEMUX_BEAT_CNT_EN
        , .CNT1(cnt1), .CNT2(cnt2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_d = '0; s = 1'b0; i_valid = 1'b0; y1_ready = 1'b0; y2_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_y1", y1, 0);
        check("rst_y2", y2, 0);
        check("rst_v1", y1_valid, 0);
        check("rst_v2", y2_valid, 0);
        // single beat to Y1, then hold it stalled
        i_d = 8'hA5; s = 1'b0; i_valid = 1'b1;
        #1 check("t2_ird", i_ready, 1);
        step();
        i_valid = 1'b0;
        check("t2_y1", y1, 8'hA5);
        check("t2_v1", y1_valid, 1);
        check("t2_v2", y2_valid, 0);
        check("t2_ird_full", i_ready, 0);
        // async reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1 check("t1_async_v1", y1_valid, 0);
        check("t1_async_y1", y1, 0);
        step();
        rst_n = 1'b1;
        // alternating stream, both consumers ready
        y1_ready = 1'b1; y2_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_d = 8'(k); s = k[0]; i_valid = 1'b1;
            #1 check($sformatf("t3_ird%0d", k), i_ready, 1);
            step();
            if (k[0]) begin
                check($sformatf("t3_y2_%0d", k), {y2_valid, y2}, {1'b1, 8'(k)});
                check($sformatf("t3_v1_%0d", k), y1_valid, 0);
            end else begin
                check($sformatf("t3_y1_%0d", k), {y1_valid, y1}, {1'b1, 8'(k)});
                check($sformatf("t3_v2_%0d", k), y2_valid, 0);
            end
        end
        i_valid = 1'b0;
        step();
        check("t3_drain", {y1_valid, y2_valid}, 0);
        // Y2 stalled: its beats wait, Y1 beats still pass
        y2_ready = 1'b0;
        i_d = 8'h77; s = 1'b1; i_valid = 1'b1;
        step();
        check("t4_y2_load", {y2_valid, y2}, {1'b1, 8'h77});
        i_d = 8'h99;
        #1 check("t4_ird_stall", i_ready, 0);
        step();
        check("t4_y2_stable", {y2_valid, y2}, {1'b1, 8'h77});
        check("t4_ird_stall2", i_ready, 0);
        i_d = 8'h3C; s = 1'b0;
        #1 check("t4_ird_other", i_ready, 1);
        step();
        check("t4_y1", {y1_valid, y1}, {1'b1, 8'h3C});
        check("t4_y2_still", {y2_valid, y2}, {1'b1, 8'h77});
        i_d = 8'h99; s = 1'b1;
        #1 check("t4_ird_pend", i_ready, 0);
        y2_ready = 1'b1;
        #1 check("t4_ird_rel", i_ready, 1);
        step();
        check("t4_y2_new", {y2_valid, y2}, {1'b1, 8'h99});
        check("t4_v1_drained", y1_valid, 0);
        i_valid = 1'b0;
        step();
        // drain and refill Y1 in the same cycle
        i_d = 8'h20; s = 1'b0; i_valid = 1'b1;
        step();
        check("t5_y1_a", {y1_valid, y1}, {1'b1, 8'h20});
        i_d = 8'h11;
        #1 check("t5_ird", i_ready, 1);
        step();
        check("t5_y1_b", {y1_valid, y1}, {1'b1, 8'h11});
        i_valid = 1'b0;
        step();
        check("t5_keep", {y1_valid, y1}, {1'b0, 8'h11});
        // 17 beats to Y1 from a fresh reset
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
`ifdef DEMUX_BEAT_CNT_EN
        check("t6_cnt_rst", {cnt1, cnt2}, 0);
`endif
        s = 1'b0; i_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            i_d = 8'(k + 8'h40);
            step();
        end
        i_valid = 1'b0;
        step();
        check("t6_last", {y1_valid, y1}, {1'b0, 8'h50});
        check("t6_v2", y2_valid, 0);
`ifdef DEMUX_BEAT_CNT_EN
        check("t6_cnt1", cnt1, 1);
        check("t6_cnt2", cnt2, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
